alu_ctrl_seq: RTL and testbench

- Parametrised successor to the datapath's combinational ALU control: merges aluop/funct decode with a registered WIDTH-bit ALU.
- Adds shifts, unsigned compares, signed overflow, and an iterative shift-add multiplier (mult/multu) writing hi/lo registers.
- Sits in the execute stage of the multi-cycle datapath. The controller issues start and waits for done; busy stalls the controller during multiply.

---
 rtl/alu_ctrl_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : Registered ALU with aluop/funct decode and iterative shift-add
//            multiplier (mult/multu) writing hi/lo.
// Revision : 1.0
// ============================================================================
module alu_ctrl_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         aluop,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;
    localparam logic [5:0] c_fn_sll   = 6'b000000;
    localparam logic [5:0] c_fn_srl   = 6'b000010;
    localparam logic [5:0] c_fn_sra   = 6'b000011;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;

    localparam logic [SHAMT_W-1:0] c_last_step = SHAMT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 illegal_q, illegal_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     add_res, sub_res;
    logic                 add_ovf, sub_ovf;
    logic                 lt_s, lt_u;
    logic [WIDTH-1:0]     op_res;
    logic                 op_ovf, op_ill, op_mul, op_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   prod_step, prod_fix;

    assign add_res = a + b;
    assign sub_res = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;

    always_comb begin
        op_res    = '0;
        op_ovf    = 1'b0;
        op_ill    = 1'b0;
        op_mul    = 1'b0;
        op_signed = 1'b0;
        case (aluop)
            2'b00: begin
                op_res = add_res;
                op_ovf = add_ovf;
            end
            2'b01: begin
                op_res = sub_res;
                op_ovf = sub_ovf;
            end
            2'b11: op_res = a | b;
            default: begin
                case (funct)
                    c_fn_add: begin
                        op_res = add_res;
                        op_ovf = add_ovf;
                    end
                    c_fn_addu: op_res = add_res;
                    c_fn_sub: begin
                        op_res = sub_res;
                        op_ovf = sub_ovf;
                    end
                    c_fn_subu:  op_res = sub_res;
                    c_fn_and:   op_res = a & b;
                    c_fn_or:    op_res = a | b;
                    c_fn_xor:   op_res = a ^ b;
                    c_fn_nor:   op_res = ~(a | b);
                    c_fn_slt:   op_res = {{(WIDTH-1){1'b0}}, lt_s};
                    c_fn_sltu:  op_res = {{(WIDTH-1){1'b0}}, lt_u};
                    c_fn_sll:   op_res = b << shamt;
                    c_fn_srl:   op_res = b >> shamt;
                    c_fn_sra:   op_res = $unsigned($signed(b) >>> shamt);
                    c_fn_mfhi:  op_res = hi_q;
                    c_fn_mflo:  op_res = lo_q;
                    c_fn_mult: begin
                        op_mul    = 1'b1;
                        op_signed = 1'b1;
                    end
                    c_fn_multu: op_mul = 1'b1;
                    default:    op_ill = 1'b1;
                endcase
            end
        endcase
    end

    // mult runs unsigned on magnitudes; the sign is restored in FIN
    assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

    assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    assign prod_step = {step_sum, prod_q[WIDTH-1:1]};
    assign prod_fix  = neg_q ? -prod_q : prod_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        count_d   = count_q;
        neg_d     = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_mul) begin
                        state_d = ST_MUL;
                        busy_d  = 1'b1;
                        mcand_d = a_mag;
                        prod_d  = {{WIDTH{1'b0}}, b_mag};
                        count_d = '0;
                        neg_d   = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    end else begin
                        result_d  = op_res;
                        zero_d    = (op_res == '0);
                        ovf_d     = op_ovf;
                        illegal_d = op_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                prod_d  = prod_step;
                count_d = count_q + SHAMT_W'(1);
                if (count_q == c_last_step) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                {hi_d, lo_d} = prod_fix;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign ovf     = ovf_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Brief    : Scoreboard bench for alu_ctrl_seq with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_alu_ctrl_seq;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  aluop   = 2'b00;
    logic [5:0]  funct   = 6'b000000;
    logic [4:0]  shamt   = 5'd0;
    logic [31:0] a       = 32'd0;
    logic [31:0] b       = 32'd0;
    logic        busy, done, zero, ovf, illegal;
    logic [31:0] result, hi, lo;

    typedef struct {
        string       tag;
        logic        is_mul;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_ctrl_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .aluop   (aluop),
        .funct   (funct),
        .shamt   (shamt),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .ovf     (ovf),
        .illegal (illegal),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires exactly one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_mul) begin
                    chk({mon_e.tag, ".hi"}, hi, mon_e.hi);
                    chk({mon_e.tag, ".lo"}, lo, mon_e.lo);
                    chk({mon_e.tag, ".busy"}, 32'(busy), 32'd0);
                end else begin
                    chk({mon_e.tag, ".result"}, result, mon_e.res);
                    chk({mon_e.tag, ".zero"}, 32'(zero), 32'(mon_e.zero));
                    chk({mon_e.tag, ".ovf"}, 32'(ovf), 32'(mon_e.ovf));
                    chk({mon_e.tag, ".illegal"}, 32'(illegal), 32'(mon_e.ill));
                end
            end
        end
    end

    // Called at posedge+1; leaves start high so calls can run back to back
    task automatic op(input string tag, input logic [1:0] op_aluop, input logic [5:0] op_funct,
                      input logic [4:0] op_shamt, input logic [31:0] op_a, input logic [31:0] op_b,
                      input logic [31:0] exp_res, input logic exp_zero, input logic exp_ovf,
                      input logic exp_ill);
        exp_t e;
        aluop = op_aluop;
        funct = op_funct;
        shamt = op_shamt;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        e.tag = tag; e.is_mul = 1'b0; e.res = exp_res; e.zero = exp_zero;
        e.ovf = exp_ovf; e.ill = exp_ill; e.hi = 32'd0; e.lo = 32'd0;
        sb.push_back(e);
        @(posedge clk); #1;
        chk({tag, ".done_latency"}, 32'(done), 32'd1);
    endtask

    task automatic idle(input int cycles);
        start = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        chk("idle.done", 32'(done), 32'd0);
    endtask

    task automatic mul(input string tag, input logic [5:0] f, input logic [31:0] ma,
                       input logic [31:0] mb, input logic [31:0] eh, input logic [31:0] el,
                       input int inj);
        exp_t e;
        int   n;
        aluop = 2'b10;
        funct = f;
        a     = ma;
        b     = mb;
        start = 1'b1;
        e.tag = tag; e.is_mul = 1'b1; e.res = 32'd0; e.zero = 1'b0;
        e.ovf = 1'b0; e.ill = 1'b0; e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (inj != 0 && n == inj) begin
                start = 1'b1;
                aluop = 2'b00;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(n), 32'd33);
        chk({tag, ".done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op("add3_4", 2'b00, 6'd0, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
        op("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, 32'd1, 1'b0, 1'b0, 1'b0);
        op("sltu", 2'b10, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(1);

        op("beq_sub", 2'b01, 6'd0, 5'd0, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        op("add_ovf", 2'b00, 6'd0, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        op("addu", 2'b10, 6'b100001, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b0);
        op("sub_ovf", 2'b10, 6'b100010, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        op("ori", 2'b11, 6'd0, 5'd0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0);
        idle(2);

        mul("mult", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        op("mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);
        op("mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(1);

        mul("multu", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        chk("multu.result_held", result, 32'hFFFFFFFF);
        op("mfhi2", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'h1, 1'b0, 1'b0, 1'b0);
        idle(1);

        op("sra", 2'b10, 6'b000011, 5'd4, 32'd0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0);
        op("srl", 2'b10, 6'b000010, 5'd4, 32'd0, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0);
        op("sll", 2'b10, 6'b000000, 5'd31, 32'd0, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b0);
        op("illegal", 2'b10, 6'b001111, 5'd0, 32'h12345678, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
        op("and", 2'b10, 6'b100100, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0);
        op("xor", 2'b10, 6'b100110, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
        op("nor", 2'b10, 6'b100111, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op("subu", 2'b10, 6'b100011, 5'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op("add_fn_ovf", 2'b10, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Abort a multiply part-way: hi still holds 1 from multu beforehand
        aluop = 2'b10;
        funct = 6'b011000;
        a     = 32'd5;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("post_abort_add", 2'b00, 6'd0, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
        idle(3);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
